pll_phase_ctrl: RTL

//  Dynamic phase-shift sequencer for the ECP5 EHXPLLL; a parametrised successor to the static PLL wrapper.

---
 rtl/pll_phase_pkg.sv | 31 +++
 rtl/pll_lock_filter.sv | 43 ++++
 rtl/pll_phase_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types for the EHXPLLL dynamic phase-shift sequencer.
// Holds the FSM state encoding, the PHASESEL channel codes and parameter helpers.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_SETTLE,
        ST_WAITLK,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_CLKOS  = 2'd0,
        SEL_CLKOS2 = 2'd1,
        SEL_CLKOS3 = 2'd2,
        SEL_CLKOP  = 2'd3
    } phasesel_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer holds (cycles - 1), so clog2 of the longest interval is enough.
    function automatic int timer_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the raw PLL LOCK and qualifies it with a saturating run-length counter.
// locked_stable_o is high only after LOCK_FILTER consecutive synced-high cycles.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 256
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pll_locked_i,
    output logic locked_stable_o
);

    localparam int CNT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign locked_stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL: turns step requests into
// PHASESEL/PHASEDIR/PHASESTEP sequences and tracks a signed position per channel.
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int STEP_W        = 8,
    parameter int PHASE_W       = 8,
    parameter int SETUP_CYCLES  = 4,
    parameter int PULSE_CYCLES  = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_FILTER   = 256
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      pll_locked_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_ch_i,
    input  logic                      req_dir_i,
    input  logic [STEP_W-1:0]         req_steps_i,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      lock_lost_o,
    output logic                      locked_stable_o,
    output logic [NUM_CH*PHASE_W-1:0] phase_pos_o,
    output logic [1:0]                phasesel_o,
    output logic                      phasedir_o,
    output logic                      phasestep_o,
    output logic                      phaseloadreg_o
);

    localparam int MAX_T = max2(max2(SETUP_CYCLES, PULSE_CYCLES),
                                max2(GAP_CYCLES, SETTLE_CYCLES));
    localparam int TMR_W = timer_width(MAX_T);

    localparam logic [TMR_W-1:0] T_SETUP  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_PULSE  = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_GAP    = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       NUM_CH_L = 3'(NUM_CH);

    state_e              state_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [STEP_W-1:0]   rem_q;
    logic [1:0]          ch_q;
    logic                dir_q;
    logic                busy_q;
    logic                done_q;
    logic                lost_q;
    logic [1:0]          sel_q;
    logic                pdir_q;
    logic                step_q;
    logic [PHASE_W-1:0]  pos_q [NUM_CH];
    logic [PHASE_W-1:0]  pos_d [NUM_CH];

    logic locked_stable;
    logic accept;
    logic req_null;
    logic tmr_zero;
    logic step_now;

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .pll_locked_i   (pll_locked_i),
        .locked_stable_o(locked_stable)
    );

    assign req_ready_o = (state_q == ST_IDLE) & locked_stable & ~reset_i;
    assign accept      = req_valid_i & req_ready_o;
    assign req_null    = (req_steps_i == '0) || ({1'b0, req_ch_i} >= NUM_CH_L);
    assign tmr_zero    = (tmr_q == '0);
    // A pulse already in flight still counts when lock drops mid-pulse.
    assign step_now    = (state_q == ST_PULSE) && (tmr_zero || !locked_stable);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pos_d[c] = pos_q[c];
            if (step_now && (ch_q == 2'(c))) begin
                pos_d[c] = dir_q ? pos_q[c] + PHASE_W'(1) : pos_q[c] - PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset_i) begin
                pos_q[c] <= '0;
            end else begin
                pos_q[c] <= pos_d[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            sel_q   <= SEL_CLKOS;
            pdir_q  <= 1'b0;
            step_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ch_q   <= req_ch_i;
                        dir_q  <= req_dir_i;
                        rem_q  <= req_steps_i;
                        sel_q  <= req_ch_i;
                        pdir_q <= req_dir_i;
                        lost_q <= 1'b0;
                        if (req_null) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SETUP;
                            tmr_q   <= T_SETUP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (!locked_stable) begin
                        lost_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                        tmr_q   <= T_SETTLE;
                    end else if (tmr_zero) begin
                        state_q <= ST_PULSE;
                        tmr_q   <= T_PULSE;
                        step_q  <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (step_now) begin
                        rem_q  <= rem_q - STEP_W'(1);
                        step_q <= 1'b1;
                        if (!locked_stable) begin
                            lost_q  <= 1'b1;
                            state_q <= ST_SETTLE;
                            tmr_q   <= T_SETTLE;
                        end else begin
                            state_q <= ST_GAP;
                            tmr_q   <= T_GAP;
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!locked_stable) begin
                        lost_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                        tmr_q   <= T_SETTLE;
                    end else if (tmr_zero) begin
                        if (rem_q != '0) begin
                            state_q <= ST_PULSE;
                            tmr_q   <= T_PULSE;
                            step_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SETTLE;
                            tmr_q   <= T_SETTLE;
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_SETTLE: begin
                    // Skip WAITLK entirely when lock is already qualified.
                    if (tmr_zero) begin
                        if (locked_stable) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_WAITLK;
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_WAITLK: begin
                    if (locked_stable) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        phase_pos_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            phase_pos_o[c*PHASE_W +: PHASE_W] = pos_q[c];
        end
    end

    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign lock_lost_o     = lost_q;
    assign locked_stable_o = locked_stable;
    assign phasesel_o      = sel_q;
    assign phasedir_o      = pdir_q;
    assign phasestep_o     = step_q;
    assign phaseloadreg_o  = 1'b1;

endmodule
